// File: rtl/stall_mem_responder_pkg.sv
// Shared types and constants for the stall-aware data-memory responder.
package stall_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int CNT_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Big-endian: the lower byte address holds the most significant byte.
    localparam int BYTE_OFS_HI = 0;
    localparam int BYTE_OFS_LO = 1;
    localparam int LANE_HI_LSB = 8;
    localparam int LANE_LO_LSB = 0;

    function automatic int clamp_latency(input int lat);
        if (lat < LATENCY_MIN) return LATENCY_MIN;
        if (lat > LATENCY_MAX) return LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/stall_mem_responder_if.sv
// Core-to-memory request interface: the core is master, the responder is slave.
interface stall_mem_responder_if;
    import stall_mem_responder_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              done;
    logic              err;
    logic              stall;

    modport master (
        output req, wr, addr, data_in,
        input  data_out, done, err, stall
    );

    modport slave (
        input  req, wr, addr, data_in,
        output data_out, done, err, stall
    );

endinterface

// File: rtl/stall_mem_responder_mem.sv
// Byte-addressed storage with a big-endian 16-bit word port; contents are never reset.
module mem_byte_array
    import stall_mem_responder_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [7:0]    bytes_q [2**AW];
    logic [AW-1:0] addr_hi;
    logic [AW-1:0] addr_lo;

    // Word addresses are even, so the low-byte address never wraps.
    assign addr_hi = addr + AW'(BYTE_OFS_HI);
    assign addr_lo = addr + AW'(BYTE_OFS_LO);

    always_ff @(posedge clk) begin
        if (we) begin
            bytes_q[addr_hi] <= wdata[LANE_HI_LSB +: 8];
            bytes_q[addr_lo] <= wdata[LANE_LO_LSB +: 8];
        end
    end

    assign rdata[LANE_HI_LSB +: 8] = bytes_q[addr_hi];
    assign rdata[LANE_LO_LSB +: 8] = bytes_q[addr_lo];

endmodule

// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the core for
// LATENCY cycles, performs the access, then pulses done (with err if misaligned).
module stall_mem_responder
    import stall_mem_responder_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int AW      = 10
) (
    input logic                  clk,
    input logic                  rst,
    stall_mem_responder_if.slave bus
);

    // Out-of-range latencies are pulled into the counter's representable range.
    localparam int               LAT      = clamp_latency(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q;
    logic              wr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] data_out_q;
    logic              done_q;
    logic              err_q;
    logic              accept;
    logic              misalign;
    logic              access;

    assign accept   = (state_q == IDLE) && bus.req;
    assign misalign = bus.addr[0];
    assign access   = (state_q == WAIT) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (misalign) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == RESP);
            err_q   <= accept && misalign;
            if (access && !wr_q) data_out_q <= rdata;
        end
    end

    // Request fields are only meaningful once accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr[AW-1:0];
            wr_q    <= bus.wr;
            wdata_q <= bus.data_in;
        end
    end

    mem_byte_array #(.AW(AW)) u_mem (
        .clk   (clk),
        .we    (access && wr_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Stall is released during reset and in RESP so the core advances with done.
    assign bus.stall    = rst && (accept || (state_q == WAIT));
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed bench for stall_mem_responder with a transaction-level reference model.
module tb_stall_mem_responder;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stall_mem_responder_if bus();

    stall_mem_responder #(.LATENCY(LAT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each transaction has an absolute done cycle; the access
    // lands at the end of the cycle before it, and the responder frees at its end.
    logic [7:0]    mmem [0:(1<<AW)-1];
    bit            m_busy   = 1'b0;
    int            m_cyc    = 0;
    int            m_done_at = 0;
    bit            m_wr     = 1'b0;
    bit            m_err    = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [AW-1:0] m_lo;
    logic [15:0]   m_wdata  = '0;
    logic [15:0]   m_dout   = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_dout = 16'h0000;
        end else begin
            if (m_busy) begin
                if (!m_err && m_cyc == m_done_at - 1) begin
                    m_lo = m_addr + AW'(1);
                    if (m_wr) begin
                        mmem[m_addr] = m_wdata[15:8];
                        mmem[m_lo]   = m_wdata[7:0];
                    end else begin
                        m_dout = {mmem[m_addr], mmem[m_lo]};
                    end
                end
                if (m_cyc == m_done_at) m_busy = 1'b0;
            end else if (bus.req) begin
                m_busy    = 1'b1;
                m_wr      = bus.wr;
                m_addr    = bus.addr[AW-1:0];
                m_wdata   = bus.data_in;
                m_err     = bus.addr[0];
                m_done_at = m_cyc + (m_err ? 1 : LAT + 1);
            end
            m_cyc++;
        end
    end

    logic e_done, e_err, e_stall;

    always @(negedge clk) begin
        e_done  = m_busy && (m_cyc == m_done_at);
        e_err   = e_done && m_err;
        e_stall = rst && ((!m_busy && bus.req) || (m_busy && m_cyc < m_done_at));
        check("model_done",     32'(bus.done),     32'(e_done));
        check("model_err",      32'(bus.err),      32'(e_err));
        check("model_stall",    32'(bus.stall),    32'(e_stall));
        check("model_data_out", 32'(bus.data_out), 32'(m_dout));
    end

    // Issues one request from posedge+1 and returns once the done cycle has ended.
    task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit poke_resp,
                       output int lat, output logic [15:0] dout, output logic e);
        bus.req     = 1'b1;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        lat  = 0;
        dout = '0;
        e    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dout = bus.data_out;
                e    = bus.err;
                if (poke_resp) bus.addr = 16'h0030;
                @(posedge clk);
                #1;
                bus.req = 1'b0;
                return;
            end
            lat++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL txn_timeout: no done within 40 cycles for addr %h", a);
        bus.req = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [15:0] dout;
    logic        e;

    initial begin
        bus.req     = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step(1);

        // Reset with a live write request: nothing happens, data_out clears.
        txn(1'b1, 16'h0040, 16'h1111, 1'b0, lat, dout, e);
        txn(1'b0, 16'h0040, 16'h0000, 1'b0, lat, dout, e);
        check("pre_reset_read", 32'(dout), 32'h0000_1111);
        rst         = 1'b0;
        bus.req     = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 16'h0040;
        bus.data_in = 16'h7E7E;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_done",     32'(bus.done),     32'h0);
            check("rst_err",      32'(bus.err),      32'h0);
            check("rst_stall",    32'(bus.stall),    32'h0);
            check("rst_data_out", 32'(bus.data_out), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        rst     = 1'b1;
        step(1);
        txn(1'b0, 16'h0040, 16'h0000, 1'b0, lat, dout, e);
        check("post_reset_read", 32'(dout), 32'h0000_1111);

        // Aligned write then read with LATENCY=4.
        txn(1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, dout, e);
        check("wr_latency", 32'(lat), 32'd5);
        check("wr_err",     32'(e),   32'h0);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, dout, e);
        check("rd_latency", 32'(lat),  32'd5);
        check("rd_data",    32'(dout), 32'h0000_BEEF);
        check("rd_err",     32'(e),    32'h0);

        // Misaligned read: one-cycle error response, data_out untouched.
        txn(1'b0, 16'h0011, 16'h0000, 1'b0, lat, dout, e);
        check("mis_latency", 32'(lat),  32'd1);
        check("mis_err",     32'(e),    32'h1);
        check("mis_data",    32'(dout), 32'h0000_BEEF);

        // Reset in WAIT discards the pending write.
        txn(1'b1, 16'h0020, 16'h0000, 1'b0, lat, dout, e);
        bus.req     = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 16'h0020;
        bus.data_in = 16'h1234;
        step(2);
        rst     = 1'b0;
        bus.req = 1'b0;
        step(2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_done", 32'(bus.done), 32'h0);
        end
        step(1);
        txn(1'b0, 16'h0020, 16'h0000, 1'b0, lat, dout, e);
        check("abort_read", 32'(dout), 32'h0000_0000);

        // Upper address bits alias, then a zero-bubble back-to-back read.
        txn(1'b1, 16'hFFFE, 16'hA55A, 1'b0, lat, dout, e);
        txn(1'b0, 16'h03FE, 16'h0000, 1'b0, lat, dout, e);
        check("alias_read", 32'(dout), 32'h0000_A55A);
        txn(1'b0, 16'h0010, 16'h0000, 1'b0, lat, dout, e);
        check("b2b_latency", 32'(lat),  32'd5);
        check("b2b_data",    32'(dout), 32'h0000_BEEF);

        // Address change during RESP must not start a second transaction.
        txn(1'b0, 16'h0010, 16'h0000, 1'b1, lat, dout, e);
        check("resp_poke_data", 32'(dout), 32'h0000_BEEF);
        @(negedge clk);
        check("after_resp_stall", 32'(bus.stall), 32'h0);
        check("after_resp_done",  32'(bus.done),  32'h0);
        repeat (8) @(negedge clk);
        check("no_second_done", 32'(bus.done), 32'h0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stall_mem_responder.md
Name: stall_mem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the processor's data-memory request interface.
- Replaces the single-cycle memory model when the core is made stall-aware.
- Accepts one read or write request at a time, holds the core with stall for a programmable latency, then returns data with a one-cycle done pulse.
- Storage is byte-addressed and big-endian, with 16-bit word accesses.

Parameters:
- LATENCY, 4, wait cycles between request acceptance and the access being performed; legal range 1..15.
- AW, 10, byte-address width of the storage (2^AW bytes); upper address bits are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request valid; initiator holds it, with stable fields, until the done cycle.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  byte address; must be even.
- data_in  in  16  write data; sampled with req.
- data_out  out  16  read data; registered, valid in the done cycle, held until the next read completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned-access flag; pulses together with done.
- stall  out  1  combinational hold request to the core.

Behaviour:
- Reset: rst low forces state IDLE, counter 0, done=0, err=0, data_out=16'h0000. stall=0 while in IDLE with req=0.
  - Storage contents are not reset.
  - A pending write is discarded if rst goes low mid-operation.
- States: IDLE, WAIT, RESP. Encoding is two bits.
- IDLE, req=1 at a clock edge:
  - Capture addr, wr and data_in.
  - If addr[0]=1, go to RESP with err set. No access is performed and data_out is unchanged.
  - Otherwise load cnt=LATENCY-1 and go to WAIT.
- WAIT: cnt decrements every edge. At the edge where cnt==0, the access is performed and the state moves to RESP.
  - Read: data_out <= {mem[a], mem[a+1]}.
  - Write: mem[a] <= data_in[15:8]; mem[a+1] <= data_in[7:0].
  - a = captured addr[AW-1:0]. a+1 never wraps because a is even.
- RESP: done=1 for exactly one cycle, then unconditionally return to IDLE. req is ignored in RESP, since it still belongs to the finishing request.
- stall = (state==IDLE & req) | (state==WAIT). stall=0 in RESP, which lets the core advance in the done cycle.
- Latency:
  - An aligned request first seen in cycle n has done in cycle n+LATENCY+1.
  - A misaligned request has done in cycle n+1.
- Back-to-back: a new req is accepted in the cycle immediately after the done cycle, giving a zero-bubble restart from IDLE.
- Address aliasing: addr[15:AW] are ignored, so 0xFFFE aliases (2^AW)-2.
- err and done are registered. data_out changes only on a completed aligned read.

Decomposition:
- Shared package contains:
  - state localparams (IDLE=2'b00, WAIT=2'b01, RESP=2'b10);
  - the LATENCY range limits;
  - the big-endian byte-lane constants.
- One natural sub-module: mem_byte_array, a 2^AW x 8 storage with a 16-bit word read/write port and a 1-cycle write enable, no reset.
- The FSM, counter, capture registers and stall logic stay in stall_mem_responder.

Test Plan:
1. Reset: hold rst=0 with req=1 and random inputs -> done=0, err=0, stall=0 after the first edge, data_out=16'h0000. No write occurs: a later read of the same address returns the pre-reset value.
2. LATENCY=4, write 0xBEEF at 0x0010, then read 0x0010 -> write done in cycle n+5; stall high in cycles n..n+4 and low in n+5; the read returns data_out=16'hBEEF, done=1, err=0.
3. Read at 0x0011 -> done=1 and err=1 one cycle after the request; stall high only in the request cycle; data_out keeps the previous value 0xBEEF.
4. Write 0x0000 at 0x0020; then start a write of 0x1234 at 0x0020 and pull rst low during WAIT; release and read 0x0020 -> data_out=16'h0000, no stale done pulse.
5. With AW=10, write 0xA55A at 0xFFFE, then read 0x03FE -> data_out=16'hA55A. Then issue a read of 0x0010 in the cycle immediately after done -> accepted without a bubble, returning 16'hBEEF.
6. During a RESP cycle, change addr to 0x0030 while req stays high, then drop req -> no second transaction starts; state is IDLE and stall=0 the following cycle.
